// File: rtl/handshake_pkg.sv
// Shared types and defaults for the 4-phase bundled-data receiver.
package handshake_pkg;

    typedef enum logic {IDLE = 1'b0, ACK_HI = 1'b1} hs_state_t;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEPTH       = 4;

    // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/handshake_sync_rx_if.sv
// Upstream req/ack + bundled data and downstream valid/ready stream of the receiver.
interface handshake_sync_rx_if
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int CW = cnt_w(DEPTH);

    logic              req_i;
    logic [DATA_W-1:0] data_i;
    logic              ack_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              ready_i;
    logic [CW-1:0]     count_o;

    // master: async producer plus clocked consumer; slave: the receiver itself
    modport master (
        output req_i, data_i, ready_i,
        input  ack_o, valid_o, data_o, count_o
    );

    modport slave (
        input  req_i, data_i, ready_i,
        output ack_o, valid_o, data_o, count_o
    );

endinterface

// File: rtl/hs_rx_fifo.sv
// Small synchronous FIFO with registered occupancy; head word read straight from storage.
module hs_rx_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              vld_q;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = ~vld_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & vld_q;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt_q <= cnt_d;
            vld_q <= (cnt_d != '0);
        end
    end

endmodule

// File: rtl/handshake_sync_rx.sv
// Clocked responder terminating a 4-phase bundled-data channel into a valid/ready FIFO stream.
module handshake_sync_rx
    import handshake_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEPTH       = DEF_DEPTH,
    localparam int CW         = cnt_w(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    handshake_sync_rx_if.slave  hs
);

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    hs_state_t              state_q;
    hs_state_t              state_d;
    logic                   push;
    logic                   full;
    logic                   empty;
    logic [DATA_W-1:0]      rdata;
    logic [CW-1:0]          count;

    // Only the first flop of this chain ever sees the asynchronous req_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) req_sync <= '0;
        else       req_sync <= {req_sync[SYNC_STAGES-2:0], hs.req_i};
    end

    assign req_s = req_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A full FIFO parks us in IDLE with ack low, which stalls the async chain upstream.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s && !full) begin
                    push    = 1'b1;
                    state_d = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s) state_d = IDLE;
            end
        endcase
    end

    hs_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (push),
        .wdata  (hs.data_i),
        .pop    (hs.ready_i & ~empty),
        .rdata  (rdata),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign hs.ack_o   = (state_q == ACK_HI);
    assign hs.valid_o = ~empty;
    assign hs.data_o  = rdata;
    assign hs.count_o = count;

endmodule

// File: doc/handshake_sync_rx.md
Name: handshake_sync_rx

Overview:
- Clocked responder that terminates a 4-phase bundled-data req/ack channel driven by the asynchronous controller pipeline.
- Synchronises the incoming request and captures the bundled data into a small FIFO.
- Returns the acknowledge and presents the words to the clocked core as a valid/ready stream.
- Sits at the async-to-sync boundary, on the consumer side of the last controller stage.

Parameters:
- DATA_W, 32, width of the bundled data word.
- SYNC_STAGES, 2, number of flip-flops in the req_i synchroniser; legal range 2..4.
- DEPTH, 4, number of FIFO entries; must be a power of two, minimum 2.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  asynchronous request from the upstream controller; 4-phase, return-to-zero.
- data_i  in  DATA_W  bundled data; stable from before req_i rises until ack_o falls.
- ack_o  out  1  acknowledge to the upstream controller.
- valid_o  out  1  FIFO head is valid.
- data_o  out  DATA_W  FIFO head word.
- ready_i  in  1  consumer accepts the head word when valid_o && ready_i.
- count_o  out  $clog2(DEPTH)+1  current FIFO occupancy.

Interface decision:
- One clock; reset is synchronous and active-high (clk_i, rst_i).

Behaviour:
- Reset values, applied at the first rising edge with rst_i=1:
  - ack_o=0, valid_o=0, data_o=0, count_o=0.
  - All synchroniser flops 0; FSM in IDLE; FIFO pointers 0.
- Synchroniser: req_s is the last stage of a SYNC_STAGES-deep flop chain on req_i. No other logic samples req_i.
- FSM with two states; ack_o is a registered output equal to (state==ACK_HI):
  - IDLE: if req_s==1 and count<DEPTH → push data_i into the FIFO, go to ACK_HI. If req_s==1 and the FIFO is full → stay in IDLE with ack_o=0 (backpressure stalls the async chain).
  - ACK_HI: if req_s==0 → go to IDLE (ack_o falls). Otherwise hold. No push occurs in this state.
- Latency:
  - Edge E0 is the first edge at which req_i is sampled high.
  - With a non-full FIFO, ack_o and valid_o rise at edge E(SYNC_STAGES).
  - ack_o falls SYNC_STAGES edges after the first edge sampling req_i low.
  - Minimum handshake period is 2*(SYNC_STAGES+1) cycles.
- Exactly one push per 4-phase cycle. A req_i glitch shorter than one clock is not guaranteed to be seen; upstream must hold req_i until ack_o rises.
- FIFO:
  - Pop on valid_o && ready_i. data_o shows the head entry combinationally from storage; it is 0 when empty after reset, otherwise undefined when empty.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full check for a push uses the registered count; a pop in the same cycle does not enable a push into a full FIFO.
  - Pointers wrap modulo DEPTH; count saturates logically at DEPTH and is never exceeded.
  - ready_i while empty has no effect.
- Reset mid-handshake:
  - ack_o drops to 0 on the reset edge and all FIFO contents are discarded.
  - If req_i is still high after reset, it is treated as a new request. The upstream controller shares rst_i and is required to return req_i low.
- valid_o = (count != 0), registered alongside count.

Decomposition:
- handshake_pkg holds the state typedef (enum logic {IDLE, ACK_HI}) and the default width constants.
- One sub-module, hs_rx_fifo: parameterised DATA_W/DEPTH synchronous FIFO exposing push, pop, full, empty and count.
- The synchroniser is an inline flop chain in handshake_sync_rx, not a separate module.

Test Plan:
- Single transfer, SYNC_STAGES=2:
  - Stimulus: data_i=32'hA5A5_0001, req_i rises, ready_i=1.
  - Required: ack_o rises at E2; valid_o=1 with data_o=32'hA5A5_0001 at the same edge, popped the next cycle.
  - Then drop req_i: ack_o falls 2 edges after req_i is sampled low.
- Backpressure, ready_i=0:
  - Stimulus: 4 handshakes with data 1..4.
  - Required: count_o steps 1→4. A fifth req_i is held with ack_o=0.
  - Release: assert ready_i for one cycle → count_o=3, and the fifth ack_o rises 1 cycle later.
- Simultaneous push and pop:
  - Stimulus: count=2, ready_i=1 on the push cycle.
  - Required: count_o stays 2; FIFO order is preserved (data 10, 11, 12 in → 10, 11, 12 out).
- Wrap-around:
  - Stimulus: 10 sequential transfers 0..9 with a continuous consumer.
  - Required: output sequence 0..9 exactly, no duplicates or drops.
- Reset during ACK_HI:
  - Stimulus: assert rst_i for 1 cycle while ack_o=1 and count=2.
  - Required: next edge shows ack_o=0, valid_o=0, count_o=0.
  - With req_i forced low, no push occurs.
- Paired with two async controller stages, DELAY=25 and 15:
  - Stimulus: 3 words.
  - Required: all 3 arrive in order, and req/ack alternate strictly 4-phase with no double ack.
